// File: rtl/parallel_to_serial_pkg.sv
// rtl/parallel_to_serial_pkg.sv - shared constants and state encoding for the serial link
package parallel_to_serial_pkg;

    localparam int         DEFAULT_WIDTH = 8;
    localparam logic [7:0] COM_SYMBOL    = 8'hBC;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } tx_state_e;

endpackage

// File: rtl/parallel_to_serial_hold.sv
// rtl/parallel_to_serial_hold.sv - one-entry valid/ready holding register for the transmitter
module tx_hold_reg
    import parallel_to_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] held_data,
    output logic             held_valid
);

    logic accept;
    logic next_valid;

    assign accept = push_valid && push_ready;

    // A push on the same edge as a pop wins, so the new byte is never lost.
    always_comb begin
        next_valid = held_valid;
        if (pop) begin
            next_valid = 1'b0;
        end
        if (accept) begin
            next_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held_valid <= 1'b0;
            push_ready <= 1'b1;
            held_data  <= '0;
        end else begin
            held_valid <= next_valid;
            push_ready <= !next_valid;
            if (accept) begin
                held_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - MSB-first byte serializer with COM idle fill and post-reset sync
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] COM     = COM_SYMBOL,
    parameter int               MIN_COM = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic             DATA_OUT,
    output logic             FRAME_START,
    output logic             IS_COM,
    output logic             SYNCED
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (MIN_COM > 1) ? $clog2(MIN_COM) : 1;

    tx_state_e        state;
    tx_state_e        state_next;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    com_cnt;
    logic [CW-1:0]    com_cnt_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] frame;
    logic             frame_is_com;
    logic             load;
    logic             pop;
    logic             sync_done;
    logic [WIDTH-1:0] held_data;
    logic             held_valid;

    tx_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (CLK),
        .reset      (RESET),
        .push_data  (DATA_IN),
        .push_valid (VALID_IN),
        .push_ready (READY_OUT),
        .pop        (pop),
        .held_data  (held_data),
        .held_valid (held_valid)
    );

    assign load = (bit_cnt == '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Frame selection only matters on load edges; elsewhere the shifter runs on.
    always_comb begin
        state_next   = state;
        com_cnt_next = com_cnt;
        frame        = COM;
        frame_is_com = 1'b1;
        pop          = 1'b0;
        sync_done    = 1'b0;
        case (state)
            SYNC: begin
                if (load) begin
                    com_cnt_next = com_cnt + 1'b1;
                    if (com_cnt == CW'(MIN_COM - 1)) begin
                        state_next = RUN;
                        sync_done  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (held_valid) begin
                    frame        = held_data;
                    frame_is_com = 1'b0;
                    pop          = load;
                end
            end
            default: begin
                state_next = SYNC;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_cnt     <= '0;
            com_cnt     <= '0;
            shift_reg   <= '0;
            DATA_OUT    <= 1'b0;
            FRAME_START <= 1'b0;
            IS_COM      <= 1'b0;
            SYNCED      <= 1'b0;
        end else begin
            bit_cnt <= (bit_cnt == BW'(WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
            com_cnt <= com_cnt_next;
            if (sync_done) begin
                SYNCED <= 1'b1;
            end
            if (load) begin
                DATA_OUT    <= frame[WIDTH-1];
                shift_reg   <= frame << 1;
                FRAME_START <= 1'b1;
                IS_COM      <= frame_is_com;
            end else begin
                DATA_OUT    <= shift_reg[WIDTH-1];
                shift_reg   <= shift_reg << 1;
                FRAME_START <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb/tb_parallel_to_serial.sv - directed and randomized checks of the serializer against a frame-level model
module tb_parallel_to_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       data_out;
    logic       frame_start;
    logic       is_com;
    logic       synced;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] acc_q[$];
    bit         ob_q[$];
    bit         fs_q[$];
    bit         ic_q[$];
    bit         collect = 1'b0;
    bit         rand_gate = 1'b0;
    int         low_cnt = 0;

    always #5 clk = ~clk;

    parallel_to_serial dut (
        .CLK         (clk),
        .RESET       (rst),
        .DATA_IN     (data_in),
        .VALID_IN    (valid_in),
        .READY_OUT   (ready_out),
        .DATA_OUT    (data_out),
        .FRAME_START (frame_start),
        .IS_COM      (is_com),
        .SYNCED      (synced)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic tick();
        logic ready_pre;
        valid_in  = (tx_q.size() > 0) && (!rand_gate || ($urandom_range(0, 3) != 0));
        data_in   = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        ready_pre = ready_out;
        @(posedge clk);
        #1;
        if (valid_in && ready_pre && !rst) begin
            acc_q.push_back(tx_q.pop_front());
        end
        if (!ready_out) low_cnt++;
        if (collect) begin
            ob_q.push_back(data_out);
            fs_q.push_back(frame_start);
            ic_q.push_back(is_com);
        end
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] exp_b, input logic exp_com,
                                output logic sync0);
        logic [7:0] b;
        logic [7:0] fs;
        logic [7:0] ic;
        b = '0; fs = '0; ic = '0; sync0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            b  = {b[6:0], data_out};
            fs = {fs[6:0], frame_start};
            ic = {ic[6:0], is_com};
            if (i == 0) sync0 = synced;
        end
        check({tag, ".bits"}, 32'(b), 32'(exp_b));
        check({tag, ".fstart"}, 32'(fs), 32'h80);
        check({tag, ".is_com"}, 32'(ic), exp_com ? 32'hFF : 32'h00);
    endtask

    logic       s;
    logic [3:0] nib;
    logic [7:0] win;
    logic [7:0] rx_q[$];
    int         n;
    int         align;
    int         fs_bad;
    int         com_bad;
    int         mism;

    initial begin
        // Reset, with VALID_IN asserted to show it is ignored during reset.
        rst = 1'b1; valid_in = 1'b1; data_in = 8'h77;
        repeat (4) begin @(posedge clk); #1; end
        valid_in = 1'b0;
        check("reset.data_out", 32'(data_out), 0);
        check("reset.frame_start", 32'(frame_start), 0);
        check("reset.is_com", 32'(is_com), 0);
        check("reset.synced", 32'(synced), 0);
        check("reset.ready", 32'(ready_out), 1);

        // Idle: four COM frames, SYNCED rises with the second frame.
        rst = 1'b0;
        expect_frame("idle0", 8'hBC, 1'b1, s);
        check("idle0.synced", 32'(s), 0);
        expect_frame("idle1", 8'hBC, 1'b1, s);
        check("idle1.synced", 32'(s), 1);
        expect_frame("idle2", 8'hBC, 1'b1, s);
        expect_frame("idle3", 8'hBC, 1'b1, s);

        // Single byte after sync; READY_OUT low for the 8 cycles it waits.
        low_cnt = 0;
        tx_q.push_back(8'h3D);
        expect_frame("single.pre", 8'hBC, 1'b1, s);
        expect_frame("single.data", 8'h3D, 1'b0, s);
        expect_frame("single.post", 8'hBC, 1'b1, s);
        check("single.ready_low", 32'(low_cnt), 8);

        // Back-to-back bytes, including a data byte equal to COM.
        tx_q = '{8'hBC, 8'h3D, 8'h0C, 8'h55};
        expect_frame("b2b.pre", 8'hBC, 1'b1, s);
        expect_frame("b2b.0", 8'hBC, 1'b0, s);
        expect_frame("b2b.1", 8'h3D, 1'b0, s);
        expect_frame("b2b.2", 8'h0C, 1'b0, s);
        expect_frame("b2b.3", 8'h55, 1'b0, s);
        expect_frame("b2b.post", 8'hBC, 1'b1, s);

        // Byte offered right after reset waits through both sync frames.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        low_cnt = 0;
        tx_q = '{8'hA5, 8'h11};
        expect_frame("early.com0", 8'hBC, 1'b1, s);
        check("early.synced0", 32'(s), 0);
        expect_frame("early.com1", 8'hBC, 1'b1, s);
        expect_frame("early.a5", 8'hA5, 1'b0, s);
        expect_frame("early.11", 8'h11, 1'b0, s);
        expect_frame("early.post", 8'hBC, 1'b1, s);
        check("early.ready_low", 32'(low_cnt), 23);

        // Reset during bit 4 of a data frame with another byte pending.
        tx_q = '{8'hE7, 8'h42};
        expect_frame("midrst.pre", 8'hBC, 1'b1, s);
        nib = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            nib = {nib[2:0], data_out};
        end
        check("midrst.partial", 32'(nib), 32'hE);
        check("midrst.pending", 32'(ready_out), 0);
        rst = 1'b1;
        tick();
        check("midrst.data_out", 32'(data_out), 0);
        check("midrst.ready", 32'(ready_out), 1);
        check("midrst.synced", 32'(synced), 0);
        rst = 1'b0;
        expect_frame("midrst.com0", 8'hBC, 1'b1, s);
        expect_frame("midrst.com1", 8'hBC, 1'b1, s);
        expect_frame("midrst.com2", 8'hBC, 1'b1, s);

        // Random stream decoded by a COM-aligned receiver model.
        rst = 1'b1;
        repeat (2) tick();
        acc_q.delete();
        ob_q.delete(); fs_q.delete(); ic_q.delete();
        for (int i = 0; i < 200; i++) begin
            tx_q.push_back((i % 17 == 0) ? 8'hBC : 8'($urandom));
        end
        rst = 1'b0;
        collect = 1'b1;
        rand_gate = 1'b1;
        n = 0;
        while ((tx_q.size() > 0 || !ready_out) && n < 5000) begin
            tick();
            n++;
        end
        check("rand.timeout", 32'(n < 5000), 1);
        repeat (16) tick();
        while (ob_q.size() % 8 != 0) tick();
        collect = 1'b0;
        rand_gate = 1'b0;

        align = -1;
        for (int i = 0; i < 8 && align < 0; i++) begin
            win = '0;
            for (int j = 0; j < 8; j++) win = {win[6:0], ob_q[i + j]};
            if (win == 8'hBC) align = i;
        end
        check("rand.align", 32'(align), 0);

        fs_bad = 0; com_bad = 0;
        rx_q.delete();
        for (int j = 0; j < ob_q.size(); j++) begin
            if (fs_q[j] != ((j % 8) == 0)) fs_bad++;
        end
        for (int k = 0; k + 8 <= ob_q.size(); k += 8) begin
            win = '0;
            for (int j = 0; j < 8; j++) win = {win[6:0], ob_q[k + j]};
            if (ic_q[k]) begin
                if (win != 8'hBC) com_bad++;
            end else begin
                rx_q.push_back(win);
            end
        end
        check("rand.fstart", 32'(fs_bad), 0);
        check("rand.com_frames", 32'(com_bad), 0);
        check("rand.accepted", 32'(acc_q.size()), 200);
        check("rand.count", 32'(rx_q.size()), 32'(acc_q.size()));
        mism = 0;
        for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) begin
            if (rx_q[i] != acc_q[i]) mism++;
        end
        check("rand.bytes", 32'(mism), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
